// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_hazard_ctrl_if                                              |
// | Brief    : ID-stage decode fields in, forward selects and stall controls out |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5
) ();
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              mem_busy;
  logic              flush;
  logic [1:0]        forwardOp1;
  logic [1:0]        forwardOp2;
  logic              stall;
  logic              bubble;
  logic [1:0]        state;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, mem_busy, flush,
    input  forwardOp1, forwardOp2, stall, bubble, state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, mem_busy, flush,
    output forwardOp1, forwardOp2, stall, bubble, state
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fwd_hazard_ctrl                                                 |
// | Brief    : ALU operand forward selects, load-use stall, freeze and flush.  |
// |            Optional counters enabled by FWD_HAZARD_PERF_CNT_EN.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fwd_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
`ifdef FWD_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        fwd_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FREEZE   = 2'b10
  } state_e;

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  state_e            state_q, state_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_reg_write_q, mem_reg_write_d;

  logic              ex_fwd_ok, mem_fwd_ok, ex_load_ok;
  logic [1:0]        sel_op1, sel_op2;
  logic              hazard, frozen;
  logic [1:0]        fwd_op1, fwd_op2;
  logic              stall_c, bubble_c;

  // Register 0 and addresses beyond the file depth are never forwarded.
  function automatic logic fwd_able(input logic [REG_AW-1:0] r);
    return (r != '0) && (32'(r) < NUM_REGS_U);
  endfunction

  assign ex_fwd_ok  = ex_valid_q && ex_reg_write_q && !ex_mem_read_q && fwd_able(ex_rd_q);
  assign mem_fwd_ok = mem_valid_q && mem_reg_write_q && fwd_able(mem_rd_q);
  assign ex_load_ok = ex_valid_q && ex_mem_read_q && ex_reg_write_q && (ex_rd_q != '0);

  assign sel_op1 = !bus.id_uses_rs                          ? 2'b00 :
                   (ex_fwd_ok  && (ex_rd_q  == bus.id_rs))  ? 2'b10 :
                   (mem_fwd_ok && (mem_rd_q == bus.id_rs))  ? 2'b01 : 2'b00;
  assign sel_op2 = !bus.id_uses_rt                          ? 2'b00 :
                   (ex_fwd_ok  && (ex_rd_q  == bus.id_rt))  ? 2'b10 :
                   (mem_fwd_ok && (mem_rd_q == bus.id_rt))  ? 2'b01 : 2'b00;

  assign hazard = bus.id_valid && ex_load_ok &&
                  ((bus.id_uses_rs && (ex_rd_q == bus.id_rs)) ||
                   (bus.id_uses_rt && (ex_rd_q == bus.id_rt)));

  assign frozen = bus.mem_busy || (state_q == ST_FREEZE);

  always_comb begin
    state_d         = state_q;
    ex_valid_d      = ex_valid_q;
    ex_rd_d         = ex_rd_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_mem_read_d   = ex_mem_read_q;
    mem_valid_d     = mem_valid_q;
    mem_rd_d        = mem_rd_q;
    mem_reg_write_d = mem_reg_write_q;
    fwd_op1         = sel_op1;
    fwd_op2         = sel_op2;
    stall_c         = 1'b0;
    bubble_c        = 1'b0;

    if (frozen) begin
      // Whole pipeline holds; a hazard pending here is re-evaluated once RUN resumes.
      stall_c = 1'b1;
      state_d = bus.mem_busy ? ST_FREEZE : ST_RUN;
    end else begin
      mem_valid_d     = ex_valid_q;
      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q;
      ex_valid_d      = bus.id_valid;
      ex_rd_d         = bus.id_rd;
      ex_reg_write_d  = bus.id_reg_write;
      ex_mem_read_d   = bus.id_mem_read;
      state_d         = ST_RUN;
      if (bus.flush) begin
        bubble_c   = 1'b1;
        ex_valid_d = 1'b0;
      end else if (hazard) begin
        stall_c    = 1'b1;
        bubble_c   = 1'b1;
        fwd_op1    = 2'b00;
        fwd_op2    = 2'b00;
        ex_valid_d = 1'b0;
        state_d    = ST_LU_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_reg_write_q <= mem_reg_write_d;
    end
  end

  assign bus.forwardOp1 = rst ? 2'b00 : fwd_op1;
  assign bus.forwardOp2 = rst ? 2'b00 : fwd_op2;
  assign bus.stall      = rst ? 1'b0  : stall_c;
  assign bus.bubble     = rst ? 1'b0  : bubble_c;
  assign bus.state      = state_q;

`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (bus.stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((bus.forwardOp1 != 2'b00) || (bus.forwardOp2 != 2'b00)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fwd_hazard_ctrl                                              |
// | Brief    : Scoreboard bench for fwd_hazard_ctrl; FWD_HAZARD_PERF_CNT_EN    |
// |            adds counter checks.                                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, wr, ld;
  } instr_t;

  // An instruction that has left ID; index 0 of the queue is the youngest.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } fl_t;

  typedef struct {
    logic [1:0]  f1, f2;
    logic        stall, bubble;
    logic [1:0]  st;
    logic [31:0] sc, fc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt;
  fwd_hazard_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));
`else
  fwd_hazard_ctrl #(.REG_AW(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  int     n_total = 0;
  int     n_pass  = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  exp_t   sb[$];
  fl_t    flight[$];
  int     m_state = 0;
  longint m_sc    = 0;
  longint m_fc    = 0;
  bit     m_last_stall = 1'b0;
  instr_t cur;

  task automatic chk(input string nm, input longint act, input longint exp, input int c);
    n_total++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, c, act, exp);
    end
  endtask

  function automatic instr_t mk(input bit v, input int rs, input int rt, input bit urs,
                                input bit urt, input int rd, input bit wr, input bit ld);
    instr_t i;
    i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
    i.rd = 5'(rd); i.wr = wr; i.ld = ld;
    return i;
  endfunction

  // Youngest qualifying producer wins; a load in EX cannot supply its data yet.
  function automatic logic [1:0] ref_sel(input bit uses, input int src);
    if (!uses) return 2'd0;
    for (int age = 0; age < flight.size() && age < 2; age++) begin
      if (flight[age].v && flight[age].wr && flight[age].rd == src && src != 0) begin
        if (age == 0 && flight[age].ld) continue;
        return (age == 0) ? 2'd2 : 2'd1;
      end
    end
    return 2'd0;
  endfunction

  function automatic void advance(input bit v);
    fl_t e;
    e.v = v; e.rd = int'(cur.rd); e.wr = cur.wr; e.ld = cur.ld;
    flight.push_front(e);
    if (flight.size() > 2) void'(flight.pop_back());
  endfunction

  task automatic step(input bit r, input bit busy, input bit fl);
    exp_t e;
    bit   haz;
    @(posedge clk);
    #1;
    cyc++;
    rst              = r;
    bus.id_valid     = cur.v;
    bus.id_rs        = cur.rs;
    bus.id_rt        = cur.rt;
    bus.id_uses_rs   = cur.urs;
    bus.id_uses_rt   = cur.urt;
    bus.id_rd        = cur.rd;
    bus.id_reg_write = cur.wr;
    bus.id_mem_read  = cur.ld;
    bus.mem_busy     = busy;
    bus.flush        = fl;

    e.cyc = cyc;
    e.st  = 2'(m_state);
    e.sc  = 32'(m_sc);
    e.fc  = 32'(m_fc);
    e.f1  = ref_sel(cur.urs, int'(cur.rs));
    e.f2  = ref_sel(cur.urt, int'(cur.rt));
    e.stall  = 1'b0;
    e.bubble = 1'b0;
    haz = cur.v && flight.size() > 0 && flight[0].v && flight[0].ld && flight[0].wr &&
          flight[0].rd != 0 &&
          ((cur.urs && flight[0].rd == int'(cur.rs)) || (cur.urt && flight[0].rd == int'(cur.rt)));

    if (r) begin
      e.f1 = 2'd0; e.f2 = 2'd0;
      m_state = 0;
      flight.delete();
    end else if (busy || m_state == 2) begin
      e.stall = 1'b1;
      m_state = busy ? 2 : 0;
    end else if (fl) begin
      e.bubble = 1'b1;
      advance(1'b0);
      m_state = 0;
    end else if (haz) begin
      e.stall = 1'b1; e.bubble = 1'b1; e.f1 = 2'd0; e.f2 = 2'd0;
      advance(1'b0);
      m_state = 1;
    end else begin
      advance(cur.v);
      m_state = 0;
    end

    if (r) begin
      m_sc = 0; m_fc = 0;
    end else begin
      m_sc = (m_sc + (e.stall ? 1 : 0)) % 64'h1_0000_0000;
      m_fc = (m_fc + ((e.f1 != 0 || e.f2 != 0) ? 1 : 0)) % 64'h1_0000_0000;
    end
    m_last_stall = e.stall;
    sb.push_back(e);
    @(negedge clk);
  endtask

  function automatic instr_t rand_instr();
    bit wr;
    wr = 1'($urandom_range(0, 1));
    return mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
              wr, wr && ($urandom_range(0, 2) == 0));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("forwardOp1", bus.forwardOp1, e.f1, e.cyc);
        chk("forwardOp2", bus.forwardOp2, e.f2, e.cyc);
        chk("stall", bus.stall, e.stall, e.cyc);
        chk("bubble", bus.bubble, e.bubble, e.cyc);
        chk("state", bus.state, e.st, e.cyc);
`ifdef FWD_HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.sc, e.cyc);
        chk("fwd_cnt", fwd_cnt, e.fc, e.cyc);
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0;
    bus.id_uses_rt = 0; bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.mem_busy = 0; bus.flush = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);

    // Empty pipeline: register-file operands
    cur = mk(1, 3, 4, 1, 1, 1, 1, 0); step(0, 0, 0);
    chk("d_empty_f1", bus.forwardOp1, 0, cyc);
    chk("d_empty_f2", bus.forwardOp2, 0, cyc);
    chk("d_empty_stall", bus.stall, 0, cyc);
    chk("d_empty_state", bus.state, 0, cyc);

    // add r5 then use in rt: EX forward, then MEM forward after a filler
    cur = mk(1, 0, 0, 0, 0, 5, 1, 0); step(0, 0, 0);
    cur = mk(1, 0, 5, 0, 1, 6, 1, 0); step(0, 0, 0);
    chk("d_ex_fwd_f2", bus.forwardOp2, 2, cyc);
    cur = mk(1, 0, 0, 0, 0, 5, 1, 0); step(0, 0, 0);
    cur = mk(1, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);
    cur = mk(1, 0, 5, 0, 1, 6, 1, 0); step(0, 0, 0);
    chk("d_mem_fwd_f2", bus.forwardOp2, 1, cyc);

    // lw r7 then use in rs: one bubble, then MEM forward
    cur = mk(1, 0, 0, 0, 0, 7, 1, 1); step(0, 0, 0);
    cur = mk(1, 7, 0, 1, 0, 8, 1, 0); step(0, 0, 0);
    chk("d_lu_stall", bus.stall, 1, cyc);
    chk("d_lu_bubble", bus.bubble, 1, cyc);
    chk("d_lu_state0", bus.state, 0, cyc);
    step(0, 0, 0);
    chk("d_lu_state1", bus.state, 1, cyc);
    chk("d_lu_f1", bus.forwardOp1, 1, cyc);
    chk("d_lu_nostall", bus.stall, 0, cyc);
    cur = mk(1, 0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);
    chk("d_lu_back_run", bus.state, 0, cyc);

    // r0 is never forwarded; EX beats MEM for r9
    cur = mk(1, 0, 0, 0, 0, 0, 1, 0); step(0, 0, 0);
    cur = mk(1, 0, 0, 0, 0, 0, 1, 1); step(0, 0, 0);
    cur = mk(1, 0, 0, 1, 1, 2, 1, 0); step(0, 0, 0);
    chk("d_r0_f1", bus.forwardOp1, 0, cyc);
    chk("d_r0_f2", bus.forwardOp2, 0, cyc);
    chk("d_r0_stall", bus.stall, 0, cyc);
    cur = mk(1, 0, 0, 0, 0, 9, 1, 0); step(0, 0, 0);
    step(0, 0, 0);
    cur = mk(1, 9, 0, 1, 0, 3, 1, 0); step(0, 0, 0);
    chk("d_r9_f1", bus.forwardOp1, 2, cyc);

    // mem_busy for 3 cycles during a load-use hazard
    cur = mk(1, 0, 0, 0, 0, 7, 1, 1); step(0, 0, 0);
    cur = mk(1, 7, 0, 1, 0, 8, 1, 0); step(0, 1, 0);
    chk("d_fz_stall0", bus.stall, 1, cyc);
    chk("d_fz_bubble0", bus.bubble, 0, cyc);
    for (int i = 0; i < 3; i++) begin
      step(0, (i < 2), 0);
      chk("d_fz_state", bus.state, 2, cyc);
      chk("d_fz_stall", bus.stall, 1, cyc);
      chk("d_fz_f1_held", bus.forwardOp1, 0, cyc);
    end
    step(0, 0, 0);
    chk("d_fz_lu_bubble", bus.bubble, 1, cyc);
    step(0, 0, 0);
    chk("d_fz_lu_f1", bus.forwardOp1, 1, cyc);

    // flush with a matching load in EX
    cur = mk(1, 0, 0, 0, 0, 7, 1, 1); step(0, 0, 0);
    cur = mk(1, 7, 0, 1, 0, 8, 1, 0); step(0, 0, 1);
    chk("d_fl_bubble", bus.bubble, 1, cyc);
    chk("d_fl_stall", bus.stall, 0, cyc);
    cur = mk(1, 1, 2, 0, 0, 4, 0, 0); step(0, 0, 0);
    chk("d_fl_no_lu", bus.state, 0, cyc);

    for (int i = 0; i < 3000; i++) begin
      if (!m_last_stall) cur = rand_instr();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0, cyc);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
